hicore_default_slave: RTL and testbench
=======================================

// Module: hicore_default_slave
// PURPOSE
//  Parametrised ICB default slave: terminates every bus transaction that decodes to no real target.
//  Buffers up to OUTS_DEPTH outstanding commands, so back-to-back accesses are absorbed at full rate.
//  Returns an error or OKAY response per RSP_ERR, with a fixed read-data pattern.
//  Sits on an unused ICB fabric port, behind the address decoder.
// PARAMETERS
//  AW         32           command address width
//  DW         32           data width; multiple of 8
//  OUTS_DEPTH 2            max outstanding responses, >=1 (sets the response FIFO depth)
//  RSP_ERR    1            1: every response has rsp_err=1; 0: rsp_err=0, writes silently dropped
//  RDATA_PAT  {DW{1'b0}}   rdata returned for reads; writes return all-zero rdata
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     asynchronous reset, active low
//  icb_cmd_valid  in   1     command valid
//  icb_cmd_ready  out  1     command ready
//  icb_cmd_addr   in   AW    command address (only captured under ERRCAP)
//  icb_cmd_read   in   1     1=read, 0=write
//  icb_cmd_wdata  in   DW    write data; ignored
//  icb_cmd_wmask  in   DW/8  write byte mask; ignored
//  icb_rsp_valid  out  1     response valid
//  icb_rsp_ready  in   1     response ready
//  icb_rsp_err    out  1     response error
//  icb_rsp_rdata  out  DW    response read data
// BEHAVIOUR
//  - Reset (async, rst_n low):
//    - cnt=0, wr_ptr=rd_ptr=0; FIFO read-flag bits cleared.
//    - icb_cmd_ready=1, icb_rsp_valid=0, icb_rsp_rdata=0.
//  - Reset asserted mid-operation drops every pending response immediately; no response is ever issued for them.
//  - Accept = icb_cmd_valid & icb_cmd_ready. The FIFO stores only the read flag, at wr_ptr.
//  - Pop = icb_rsp_valid & icb_rsp_ready. rd_ptr advances.
//  - icb_cmd_ready = (cnt != OUTS_DEPTH).
//    - Depends on registered state only; no rsp_ready->cmd_ready combinational path.
//    - Full with a pop this cycle: cmd_ready stays 0 this cycle and rises next cycle.
//  - icb_rsp_valid = (cnt != 0). Minimum latency is 1 cycle: accept in cycle N gives rsp_valid in N+1. No same-cycle bypass.
//  - Push and pop in the same cycle leave cnt unchanged. Both pointers still advance.
//  - Pointers wrap modulo OUTS_DEPTH and need not be a power of two: wrap explicitly at OUTS_DEPTH-1.
//  - cnt width is $clog2(OUTS_DEPTH+1).
//  - Responses are strictly in command order.
//  - icb_rsp_rdata = head read flag ? RDATA_PAT : 0. Driven 0 when the FIFO is empty.
//  - icb_rsp_err = RSP_ERR when rsp_valid, else 0.
//  - Response outputs hold stable while rsp_valid=1 and rsp_ready=0.
//  - No state machine beyond the counter and pointer pair.
// CONFIGURATION
//  Macro HICORE_DFLT_SLV_ERRCAP_EN. When defined, adds these ports:
//    err_clr   in   1    synchronous clear of the capture state
//    err_flag  out  1    sticky; set on accept of any command while RSP_ERR=1
//    err_addr  out  AW   icb_cmd_addr of the first accepted command after reset/clear; frozen while err_flag=1
//    err_cnt   out  16   accepted erroring commands; saturates at 16'hFFFF
//  - All four reset to 0.
//  - err_clr and an accept in the same cycle: the clear wins for err_flag and err_addr.
//    Those cycles leave err_flag=0, err_addr=0, err_cnt=1.
//  - With RSP_ERR=0, err_flag, err_addr and err_cnt stay 0.
//  Macro undefined: these ports and registers do not exist. Core behaviour is identical in both builds.
// TESTING
//  1. Reset, then a read to 0x1000_0000 with rsp_ready=1 -> rsp_valid one cycle later; rsp_err=1, rdata=RDATA_PAT; cmd_ready never drops.
//  2. DEPTH=2, rsp_ready=0, four back-to-back writes -> two accepted; cmd_ready=0 from the cycle after the 2nd accept; response outputs stable.
//     Raise rsp_ready -> responses return in order; cmd_ready rises one cycle after the first pop.
//  3. DEPTH=3, rsp_ready=1, cmd_valid=1, alternating R/W over 20 cycles -> one response per cycle after the first.
//     rdata alternates PAT/0; pointers wrap 2->0 with no loss.
//  4. RSP_ERR=0, RDATA_PAT=32'hDEAD_BEEF, one read then one write -> rsp_err=0 on both; rdata=DEADBEEF, then 0.
//  5. Two commands pending, rst_n pulsed low asynchronously mid-cycle -> rsp_valid=0 immediately.
//     After release: cmd_ready=1 and no stale responses.
//  6. ERRCAP_EN: accepts to 0x40, then 0x80 -> err_addr=0x40, err_cnt=2.
//     err_clr with a simultaneous accept -> err_flag=0, err_cnt=1.
//     Force err_cnt to 16'hFFFF, one more accept -> err_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hicore_default_slave.sv
// ICB default slave: absorbs commands that decode to no target and answers them in order.
// Optional error capture ports/registers are built when HICORE_DFLT_SLV_ERRCAP_EN is defined.
module hicore_default_slave #(
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter int            OUTS_DEPTH = 2,
    parameter int            RSP_ERR    = 1,
    parameter logic [DW-1:0] RDATA_PAT  = {DW{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef HICORE_DFLT_SLV_ERRCAP_EN
    input  logic             err_clr,
    output logic             err_flag,
    output logic [AW-1:0]    err_addr,
    output logic [15:0]      err_cnt,
`endif
    input  logic             icb_cmd_valid,
    output logic             icb_cmd_ready,
    input  logic [AW-1:0]    icb_cmd_addr,
    input  logic             icb_cmd_read,
    input  logic [DW-1:0]    icb_cmd_wdata,
    input  logic [DW/8-1:0]  icb_cmd_wmask,
    output logic             icb_rsp_valid,
    input  logic             icb_rsp_ready,
    output logic             icb_rsp_err,
    output logic [DW-1:0]    icb_rsp_rdata
);

    localparam int            CW          = $clog2(OUTS_DEPTH + 1);
    localparam int            PW          = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_FULL    = CW'(OUTS_DEPTH);
    localparam logic [PW-1:0] PTR_LAST    = PW'(OUTS_DEPTH - 1);
    localparam logic          RSP_ERR_BIT = (RSP_ERR != 0);

    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_nxt_s;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         wr_ptr_nxt_s;
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         rd_ptr_nxt_s;
    logic [OUTS_DEPTH-1:0] rd_flag_r;
    logic                  push_s;
    logic                  pop_s;

    // Depth need not be a power of two, so the wrap is explicit.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Occupancy, pointers and the per-entry read flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CW{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            rd_flag_r <= {OUTS_DEPTH{1'b0}};
        end else begin
            cnt_r    <= cnt_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            if (push_s) begin
                rd_flag_r[wr_ptr_r] <= icb_cmd_read;
            end
        end
    end

    // Handshakes and next occupancy/pointer values.
    always_comb begin
        push_s = icb_cmd_valid & icb_cmd_ready;
        pop_s  = icb_rsp_valid & icb_rsp_ready;
        if (push_s && !pop_s) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else if (pop_s && !push_s) begin
            cnt_nxt_s = cnt_r - CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
        if (push_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Bus outputs come from registered state only; no ready-to-ready path.
    always_comb begin
        icb_cmd_ready = (cnt_r != CNT_FULL);
        icb_rsp_valid = (cnt_r != {CW{1'b0}});
        icb_rsp_err   = icb_rsp_valid & RSP_ERR_BIT;
        if (icb_rsp_valid && rd_flag_r[rd_ptr_r]) begin
            icb_rsp_rdata = RDATA_PAT;
        end else begin
            icb_rsp_rdata = {DW{1'b0}};
        end
    end

`ifdef HICORE_DFLT_SLV_ERRCAP_EN
    logic          err_flag_r;
    logic [AW-1:0] err_addr_r;
    logic [15:0]   err_cnt_r;
    logic          err_hit_s;

    assign err_hit_s = push_s & RSP_ERR_BIT;

    // Capture of the first erroring address plus a saturating error count; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_r <= 1'b0;
            err_addr_r <= {AW{1'b0}};
            err_cnt_r  <= 16'h0000;
        end else if (err_clr) begin
            err_flag_r <= 1'b0;
            err_addr_r <= {AW{1'b0}};
            err_cnt_r  <= err_hit_s ? 16'h0001 : 16'h0000;
        end else if (err_hit_s) begin
            if (!err_flag_r) begin
                err_flag_r <= 1'b1;
                err_addr_r <= icb_cmd_addr;
            end
            if (err_cnt_r != 16'hFFFF) begin
                err_cnt_r <= err_cnt_r + 16'h0001;
            end
        end
    end

    assign err_flag = err_flag_r;
    assign err_addr = err_addr_r;
    assign err_cnt  = err_cnt_r;

    logic unused_s;
    assign unused_s = ^{icb_cmd_wdata, icb_cmd_wmask};
`else
    logic unused_s;
    assign unused_s = ^{icb_cmd_wdata, icb_cmd_wmask, icb_cmd_addr};
`endif

endmodule

// File: tb/tb_hicore_default_slave.sv
// Directed bench for hicore_default_slave: three instances cover depth 2 error slave,
// depth 3 streaming, and an OKAY-responding slave.
module tb_hicore_default_slave;

    localparam logic [31:0] PAT_A = 32'hA5A5_0F0F;
    localparam logic [31:0] PAT_B = 32'h1234_5678;
    localparam logic [31:0] PAT_C = 32'hDEAD_BEEF;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic        a_valid, a_ready, a_read, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_wmask;
    logic        b_valid, b_ready, b_read, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_wmask;
    logic        c_valid, c_ready, c_read, c_rsp_valid, c_rsp_ready, c_rsp_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_wmask;
`ifdef HICORE_DFLT_SLV_ERRCAP_EN
    logic        a_err_clr, a_err_flag, b_err_clr, b_err_flag, c_err_clr, c_err_flag;
    logic [31:0] a_err_addr, b_err_addr, c_err_addr;
    logic [15:0] a_err_cnt, b_err_cnt, c_err_cnt;
`endif

    hicore_default_slave #(.AW(32), .DW(32), .OUTS_DEPTH(2), .RSP_ERR(1), .RDATA_PAT(PAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
`ifdef HICORE_DFLT_SLV_ERRCAP_EN
        .err_clr(a_err_clr), .err_flag(a_err_flag), .err_addr(a_err_addr), .err_cnt(a_err_cnt),
`endif
        .icb_cmd_valid(a_valid), .icb_cmd_ready(a_ready), .icb_cmd_addr(a_addr),
        .icb_cmd_read(a_read), .icb_cmd_wdata(a_wdata), .icb_cmd_wmask(a_wmask),
        .icb_rsp_valid(a_rsp_valid), .icb_rsp_ready(a_rsp_ready),
        .icb_rsp_err(a_rsp_err), .icb_rsp_rdata(a_rdata)
    );

    hicore_default_slave #(.AW(32), .DW(32), .OUTS_DEPTH(3), .RSP_ERR(1), .RDATA_PAT(PAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
`ifdef HICORE_DFLT_SLV_ERRCAP_EN
        .err_clr(b_err_clr), .err_flag(b_err_flag), .err_addr(b_err_addr), .err_cnt(b_err_cnt),
`endif
        .icb_cmd_valid(b_valid), .icb_cmd_ready(b_ready), .icb_cmd_addr(b_addr),
        .icb_cmd_read(b_read), .icb_cmd_wdata(b_wdata), .icb_cmd_wmask(b_wmask),
        .icb_rsp_valid(b_rsp_valid), .icb_rsp_ready(b_rsp_ready),
        .icb_rsp_err(b_rsp_err), .icb_rsp_rdata(b_rdata)
    );

    hicore_default_slave #(.AW(32), .DW(32), .OUTS_DEPTH(2), .RSP_ERR(0), .RDATA_PAT(PAT_C)) dut_c (
        .clk(clk), .rst_n(rst_n),
`ifdef HICORE_DFLT_SLV_ERRCAP_EN
        .err_clr(c_err_clr), .err_flag(c_err_flag), .err_addr(c_err_addr), .err_cnt(c_err_cnt),
`endif
        .icb_cmd_valid(c_valid), .icb_cmd_ready(c_ready), .icb_cmd_addr(c_addr),
        .icb_cmd_read(c_read), .icb_cmd_wdata(c_wdata), .icb_cmd_wmask(c_wmask),
        .icb_rsp_valid(c_rsp_valid), .icb_rsp_ready(c_rsp_ready),
        .icb_rsp_err(c_rsp_err), .icb_rsp_rdata(c_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", a_ready); end
        n_cmp++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", a_rsp_valid); end
        n_cmp++; if (a_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
        n_cmp++; if (a_rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", a_rsp_err); end
        n_cmp++; if (b_rsp_valid !== 1'b0 || b_ready !== 1'b1) begin n_err++; $display("FAIL reset_b: valid %b ready %b want 0/1", b_rsp_valid, b_ready); end
    endtask

    task automatic test_single_read();
        a_valid = 1'b1; a_read = 1'b1; a_addr = 32'h1000_0000; a_rsp_ready = 1'b1;
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL read_cmd_ready: got %b want 1", a_ready); end
        @(negedge clk);
        a_valid = 1'b0;
        n_cmp++; if (a_rsp_valid !== 1'b1) begin n_err++; $display("FAIL read_rsp_valid: got %b want 1", a_rsp_valid); end
        n_cmp++; if (a_rsp_err !== 1'b1) begin n_err++; $display("FAIL read_rsp_err: got %b want 1", a_rsp_err); end
        n_cmp++; if (a_rdata !== PAT_A) begin n_err++; $display("FAIL read_rdata: got %h want %h", a_rdata, PAT_A); end
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL read_cmd_ready_hold: got %b want 1", a_ready); end
        @(negedge clk);
        n_cmp++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL read_drain: got %b want 0", a_rsp_valid); end
        n_cmp++; if (a_rdata !== 32'h0) begin n_err++; $display("FAIL read_empty_rdata: got %h want 0", a_rdata); end
    endtask

    task automatic test_backpressure();
        a_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_read = (i == 0);
            @(negedge clk);
            n_cmp++; if (a_ready !== (i == 0)) begin n_err++; $display("FAIL bp_cmd_ready[%0d]: got %b want %b", i, a_ready, (i == 0)); end
            n_cmp++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b1 || a_rdata !== PAT_A) begin
                n_err++; $display("FAIL bp_hold[%0d]: valid %b err %b rdata %h want 1/1/%h", i, a_rsp_valid, a_rsp_err, a_rdata, PAT_A);
            end
        end
        a_read = 1'b1; a_rsp_ready = 1'b1;
        n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_pop_ready: got %b want 0", a_ready); end
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_rise: got %b want 1", a_ready); end
        n_cmp++; if (a_rsp_valid !== 1'b1 || a_rdata !== 32'h0) begin n_err++; $display("FAIL bp_second_rsp: valid %b rdata %h want 1/0", a_rsp_valid, a_rdata); end
        @(negedge clk);
        a_valid = 1'b0;
        n_cmp++; if (a_rsp_valid !== 1'b1 || a_rdata !== PAT_A) begin n_err++; $display("FAIL bp_third_rsp: valid %b rdata %h want 1/%h", a_rsp_valid, a_rdata, PAT_A); end
        @(negedge clk);
        n_cmp++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", a_rsp_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_d;
        b_rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                exp_d = ((i - 1) % 2 == 0) ? PAT_B : 32'h0;
                n_cmp++; if (b_rsp_valid !== 1'b1 || b_rdata !== exp_d) begin
                    n_err++; $display("FAIL stream_rsp[%0d]: valid %b rdata %h want 1/%h", i, b_rsp_valid, b_rdata, exp_d);
                end
                n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want 1", i, b_ready); end
            end
            b_valid = 1'b1; b_read = (i % 2 == 0);
            @(negedge clk);
        end
        b_valid = 1'b0;
        n_cmp++; if (b_rsp_valid !== 1'b1 || b_rdata !== 32'h0) begin n_err++; $display("FAIL stream_last: valid %b rdata %h want 1/0", b_rsp_valid, b_rdata); end
        @(negedge clk);
        n_cmp++; if (b_rsp_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", b_rsp_valid); end
    endtask

    task automatic test_okay_rsp();
        c_rsp_ready = 1'b1; c_valid = 1'b1; c_read = 1'b1;
        @(negedge clk);
        c_read = 1'b0;
        n_cmp++; if (c_rsp_valid !== 1'b1 || c_rsp_err !== 1'b0 || c_rdata !== PAT_C) begin
            n_err++; $display("FAIL okay_read: valid %b err %b rdata %h want 1/0/%h", c_rsp_valid, c_rsp_err, c_rdata, PAT_C);
        end
        @(negedge clk);
        c_valid = 1'b0;
        n_cmp++; if (c_rsp_valid !== 1'b1 || c_rsp_err !== 1'b0 || c_rdata !== 32'h0) begin
            n_err++; $display("FAIL okay_write: valid %b err %b rdata %h want 1/0/0", c_rsp_valid, c_rsp_err, c_rdata);
        end
        @(negedge clk);
        n_cmp++; if (c_rsp_valid !== 1'b0) begin n_err++; $display("FAIL okay_drain: got %b want 0", c_rsp_valid); end
    endtask

    task automatic test_async_reset();
        a_rsp_ready = 1'b0; a_valid = 1'b1; a_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        n_cmp++; if (a_rsp_valid !== 1'b1 || a_ready !== 1'b0) begin n_err++; $display("FAIL arst_pending: valid %b ready %b want 1/0", a_rsp_valid, a_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL arst_rsp_valid: got %b want 0", a_rsp_valid); end
        n_cmp++; if (a_ready !== 1'b1 || a_rdata !== 32'h0) begin n_err++; $display("FAIL arst_ready_rdata: ready %b rdata %h want 1/0", a_ready, a_rdata); end
        @(negedge clk);
        rst_n = 1'b1; a_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (a_rsp_valid !== 1'b0 || a_ready !== 1'b1) begin
                n_err++; $display("FAIL arst_stale[%0d]: valid %b ready %b want 0/1", i, a_rsp_valid, a_ready);
            end
        end
    endtask

`ifdef HICORE_DFLT_SLV_ERRCAP_EN
    task automatic test_errcap();
        a_rsp_ready = 1'b1; a_valid = 1'b1; a_read = 1'b0; a_addr = 32'h0000_0040;
        @(negedge clk);
        a_addr = 32'h0000_0080;
        @(negedge clk);
        a_valid = 1'b0;
        n_cmp++; if (a_err_flag !== 1'b1 || a_err_addr !== 32'h40 || a_err_cnt !== 16'd2) begin
            n_err++; $display("FAIL errcap_capture: flag %b addr %h cnt %0d want 1/40/2", a_err_flag, a_err_addr, a_err_cnt);
        end
        n_cmp++; if (c_err_flag !== 1'b0 || c_err_cnt !== 16'd0) begin n_err++; $display("FAIL errcap_okay_slave: flag %b cnt %0d want 0/0", c_err_flag, c_err_cnt); end
        a_err_clr = 1'b1; a_valid = 1'b1; a_addr = 32'h0000_00C0;
        @(negedge clk);
        a_err_clr = 1'b0; a_valid = 1'b0;
        n_cmp++; if (a_err_flag !== 1'b0 || a_err_addr !== 32'h0 || a_err_cnt !== 16'd1) begin
            n_err++; $display("FAIL errcap_clear: flag %b addr %h cnt %0d want 0/0/1", a_err_flag, a_err_addr, a_err_cnt);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        n_cmp = 0; n_err = 0; rst_n = 1'b0;
        a_valid = 1'b0; a_read = 1'b0; a_addr = 32'h0; a_wdata = 32'h1111_1111; a_wmask = 4'hF; a_rsp_ready = 1'b0;
        b_valid = 1'b0; b_read = 1'b0; b_addr = 32'h0; b_wdata = 32'h2222_2222; b_wmask = 4'hF; b_rsp_ready = 1'b0;
        c_valid = 1'b0; c_read = 1'b0; c_addr = 32'h0; c_wdata = 32'h3333_3333; c_wmask = 4'hF; c_rsp_ready = 1'b0;
`ifdef HICORE_DFLT_SLV_ERRCAP_EN
        a_err_clr = 1'b0; b_err_clr = 1'b0; c_err_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_read();
        test_backpressure();
        test_stream();
        test_okay_rsp();
        test_async_reset();
`ifdef HICORE_DFLT_SLV_ERRCAP_EN
        test_errcap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
